// File: rtl/prio_ager.sv
// prio_ager: registered request/priority builder with starvation aging, feeding priority_arbiter.
// Optional macro PRIO_AGER_FLOOR_EN: aging saturates at AGE_FLOOR instead of 0.
module prio_ager #(
    parameter int N          = 8,
    parameter int PRIO_BITS  = 3,
    parameter int AGE_PERIOD = 4,
    parameter int AGE_FLOOR  = 1,
    localparam int SEL_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] base_prio_i,
    input  logic                   grant_i,
    input  logic [SEL_W-1:0]       grant_sel_i,
    output logic [N-1:0]           req_o,
    output logic [N*PRIO_BITS-1:0] prio_o
);

    localparam int CNT_W = $clog2(AGE_PERIOD) + 1;

`ifdef PRIO_AGER_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    localparam logic [PRIO_BITS-1:0] FLOOR    = FLOOR_EN ? PRIO_BITS'(AGE_FLOOR) : '0;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(AGE_PERIOD - 1);

    logic [N-1:0]           req_q;
    logic [PRIO_BITS-1:0]   eff  [N];
    logic [CNT_W-1:0]       cnt  [N];
    logic [PRIO_BITS-1:0]   base [N];
    logic [PRIO_BITS-1:0]   cur  [N];
    logic [N-1:0]           hit;
    logic                   from_reset;

    // Right after reset eff holds all-ones; a request already pending then must start from base.
    always_comb begin
        hit = '0;
        for (int k = 0; k < N; k++) begin
            base[k] = base_prio_i[k*PRIO_BITS +: PRIO_BITS];
            cur[k]  = from_reset ? base[k] : eff[k];
            hit[k]  = grant_i && (grant_sel_i == SEL_W'(k)) && req_q[k];
        end
    end

    always_ff @(posedge clk_i) begin
        from_reset <= rst_i;
        if (rst_i) begin
            req_q <= '0;
            for (int k = 0; k < N; k++) begin
                eff[k] <= '1;
                cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!req_i[k]) begin
                    req_q[k] <= 1'b0;
                    eff[k]   <= base[k];
                    cnt[k]   <= '0;
                end else if (hit[k]) begin
                    req_q[k] <= 1'b1;
                    eff[k]   <= base[k];
                    cnt[k]   <= '0;
                end else if (cnt[k] == CNT_LAST) begin
                    req_q[k] <= 1'b1;
                    cnt[k]   <= '0;
                    eff[k]   <= (cur[k] > FLOOR) ? cur[k] - 1'b1 : cur[k];
                end else begin
                    req_q[k] <= 1'b1;
                    cnt[k]   <= cnt[k] + 1'b1;
                    eff[k]   <= cur[k];
                end
            end
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_pack
        assign prio_o[k*PRIO_BITS +: PRIO_BITS] = eff[k];
    end

    assign req_o = req_q;

endmodule

// File: tb/tb_prio_ager.sv
// Scoreboard bench for prio_ager: directed and random stimulus checked against a wait-count model.
module tb_prio_ager;

    localparam int N  = 8;
    localparam int PB = 3;
    localparam int P  = 4;
`ifdef PRIO_AGER_FLOOR_EN
    localparam int FLOOR = 1;
`else
    localparam int FLOOR = 0;
`endif

    logic            clk_i       = 1'b0;
    logic            rst_i       = 1'b1;
    logic [N-1:0]    req_i       = '0;
    logic [N*PB-1:0] base_prio_i = '0;
    logic            grant_i     = 1'b0;
    logic [2:0]      grant_sel_i = '0;
    logic [N-1:0]    req_o;
    logic [N*PB-1:0] prio_o;

    always #5 clk_i = ~clk_i;

    prio_ager #(
        .N(N),
        .PRIO_BITS(PB),
        .AGE_PERIOD(P),
        .AGE_FLOOR(1)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .base_prio_i(base_prio_i),
        .grant_i(grant_i),
        .grant_sel_i(grant_sel_i),
        .req_o(req_o),
        .prio_o(prio_o)
    );

    typedef struct {
        logic [N-1:0]    req;
        logic [N*PB-1:0] prio;
        int              phase;
        int              cycle;
    } exp_t;

    exp_t            sb[$];
    exp_t            cur;
    int              compared   = 0;
    int              mismatched = 0;
    int              phase      = 0;
    int              cycleNum   = 0;
    logic [N*PB-1:0] baseNext   = '0;
    logic [N-1:0]    randReq;

    // Reference: each requester remembers the base it latched and how many pending edges it has waited since.
    int latBase [N];
    int waited  [N];
    bit pending [N];
    bit afterReset = 1'b1;

    function automatic string phaseName(input int p);
        case (p)
            0: return "reset";
            1: return "aging";
            2: return "grant_restart";
            3: return "drop_invalid";
            4: return "simultaneous";
            5: return "floor";
            default: return "random";
        endcase
    endfunction

    function automatic int agedPrio(input int b, input int w);
        int d;
        if (b <= FLOOR) return b;
        d = b - (w / P);
        return (d < FLOOR) ? FLOOR : d;
    endfunction

    task automatic modelEdge(output exp_t e);
        int hitIdx;
        int b;
        hitIdx = -1;
        if (grant_i && pending[grant_sel_i]) hitIdx = int'(grant_sel_i);
        for (int k = 0; k < N; k++) begin
            b = int'(base_prio_i[k*PB +: PB]);
            if (rst_i) begin
                pending[k] = 1'b0;
                waited[k]  = 0;
            end else if (!req_i[k]) begin
                pending[k] = 1'b0;
                latBase[k] = b;
                waited[k]  = 0;
            end else if (k == hitIdx) begin
                pending[k] = 1'b1;
                latBase[k] = b;
                waited[k]  = 0;
            end else begin
                if (afterReset) latBase[k] = b;
                waited[k]  = waited[k] + 1;
                pending[k] = 1'b1;
            end
        end
        afterReset = rst_i;
        for (int k = 0; k < N; k++) begin
            e.req[k] = pending[k];
            e.prio[k*PB +: PB] = afterReset ? 3'b111 : PB'(agedPrio(latBase[k], waited[k]));
        end
        e.phase = phase;
        e.cycle = cycleNum;
    endtask

    task automatic applyStimulus(input bit rst, input logic [N-1:0] req, input bit grant, input int sel);
        exp_t e;
        @(negedge clk_i);
        rst_i       = rst;
        req_i       = req;
        base_prio_i = baseNext;
        grant_i     = grant;
        grant_sel_i = 3'(sel);
        modelEdge(e);
        sb.push_back(e);
        cycleNum++;
    endtask

    task automatic checkOutput(input exp_t e);
        compared++;
        if (req_o !== e.req) begin
            mismatched++;
            $display("[TB] FAIL req_o (%s, cycle %0d): got %b, expected %b",
                     phaseName(e.phase), e.cycle, req_o, e.req);
        end
        compared++;
        if (prio_o !== e.prio) begin
            mismatched++;
            $display("[TB] FAIL prio_o (%s, cycle %0d): got %h, expected %h",
                     phaseName(e.phase), e.cycle, prio_o, e.prio);
        end
    endtask

    // Monitor: every edge that had stimulus modelled for it gets compared just after the edge.
    always @(posedge clk_i) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            checkOutput(cur);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        phase = 0;
        for (int k = 0; k < N; k++) baseNext[k*PB +: PB] = 3'(k);
        repeat (2) applyStimulus(1'b1, 8'hFF, 1'b0, 0);
        repeat (3) applyStimulus(1'b0, 8'hFF, 1'b0, 0);

        phase = 1;
        baseNext[2*PB +: PB] = 3'd5;
        repeat (2)  applyStimulus(1'b0, 8'h00, 1'b0, 0);
        repeat (42) applyStimulus(1'b0, 8'h04, 1'b0, 0);

        phase = 2;
        baseNext[5*PB +: PB] = 3'd6;
        applyStimulus(1'b0, 8'h00, 1'b0, 0);
        repeat (12) applyStimulus(1'b0, 8'h24, 1'b0, 0);
        applyStimulus(1'b0, 8'h24, 1'b1, 2);
        repeat (9)  applyStimulus(1'b0, 8'h24, 1'b0, 0);

        phase = 3;
        applyStimulus(1'b0, 8'h20, 1'b0, 0);
        applyStimulus(1'b0, 8'h20, 1'b1, 4);
        applyStimulus(1'b0, 8'h20, 1'b1, 2);
        repeat (2) applyStimulus(1'b0, 8'h20, 1'b0, 0);

        phase = 4;
        applyStimulus(1'b1, 8'h24, 1'b1, 5);
        applyStimulus(1'b0, 8'h00, 1'b0, 0);
        repeat (6) applyStimulus(1'b0, 8'h04, 1'b0, 0);
        baseNext[2*PB +: PB] = 3'd1;
        repeat (4) applyStimulus(1'b0, 8'h04, 1'b0, 0);
        applyStimulus(1'b0, 8'h04, 1'b1, 2);
        repeat (6) applyStimulus(1'b0, 8'h04, 1'b0, 0);

        phase = 5;
        baseNext[3*PB +: PB] = 3'd4;
        baseNext[6*PB +: PB] = 3'd0;
        applyStimulus(1'b0, 8'h00, 1'b0, 0);
        repeat (20) applyStimulus(1'b0, 8'h48, 1'b0, 0);

        phase = 6;
        for (int i = 0; i < 400; i++) begin
            randReq = 8'($urandom) | 8'($urandom) | 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                baseNext[$urandom_range(0, N-1)*PB +: PB] = 3'($urandom);
            applyStimulus(($urandom_range(0, 63) == 0), randReq,
                          ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clk_i);
        #2;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/prio_ager.md
Name: prio_ager

Overview:
- Upstream stage of `priority_arbiter`. Builds the registered `req_o` and `prio_o` buses that drive the arbiter's `req_i` and `prio_i`.
- Each requester gets a static base priority plus starvation aging: the longer a request waits without a grant, the better its priority becomes.
- Numerically lower priority value = higher priority; 0 is the best.
- The consumer of the arbiter's result feeds the accepted selection back through `grant_i` / `grant_sel_i`. The winner's priority then drops back to its base.

Parameters:
- `N`, 8, number of requesters.
- `PRIO_BITS`, 3, width of each priority field.
- `AGE_PERIOD`, 4, consecutive pending cycles per one-step improvement of priority. Must be ≥1.
- `AGE_FLOOR`, 1, best value aging may reach. Used only when `PRIO_AGER_FLOOR_EN` is defined.
- `SEL_W` (localparam), `$clog2(N)` with a minimum of 1, width of the grant index.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  N  raw request per requester; level.
- `base_prio_i`  in  N*PRIO_BITS  packed base priority; requester k occupies bits [k*PRIO_BITS +: PRIO_BITS].
- `grant_i`  in  1  single-cycle pulse: the arbiter's selection was accepted this cycle.
- `grant_sel_i`  in  SEL_W  index of the accepted requester; valid only when `grant_i`=1.
- `req_o`  out  N  registered request, to the arbiter's `req_i`.
- `prio_o`  out  N*PRIO_BITS  registered effective priority, to the arbiter's `prio_i`; same packing as `base_prio_i`.

Behaviour:
- Per-requester state:
  - `eff[k]` (PRIO_BITS wide) drives `prio_o` slot k directly.
  - `cnt[k]` (`$clog2(AGE_PERIOD)+1` bits) is the age counter.
- Reset, when `rst_i`=1 at an edge:
  - `req_o` = 0, every `eff` = all-ones (lowest priority), every `cnt` = 0.
  - Reset overrides every other input, including `grant_i`.
- Define `hit[k]` = `grant_i` && (`grant_sel_i` == k) && `req_o[k]`.
  - A grant with `grant_sel_i` ≥ N, or one naming a requester with `req_o`=0, is ignored: no state change.
- Per edge, for each k, first matching rule wins:
  1. `req_i[k]`=0: `req_o[k]` <= 0, `eff[k]` <= `base_prio_i[k]`, `cnt[k]` <= 0.
  2. `hit[k]`: `req_o[k]` <= 1, `eff[k]` <= `base_prio_i[k]`, `cnt[k]` <= 0. Aging restarts from base.
  3. `req_i[k]`=1 and `cnt[k]` == AGE_PERIOD-1:
     - `cnt[k]` <= 0, `req_o[k]` <= 1.
     - `eff[k]` <= `eff[k]`-1, saturating at the floor.
     - Without the macro the floor is 0 (no wrap below 0).
  4. Otherwise (`req_i[k]`=1): `cnt[k]` <= `cnt[k]`+1, `req_o[k]` <= 1, `eff[k]` unchanged.
- Latency: 1 cycle from `req_i` to `req_o`. `eff` already equals base while idle, so the first pending cycle presents base priority.
- With `req_i[k]` held from edge 1 and no grant:
  - `eff` = base after edges 1..AGE_PERIOD-1.
  - First decrement lands at edge AGE_PERIOD, then every AGE_PERIOD edges.
- `base_prio_i` changes while a request is pending are ignored. The new value is sampled only on rule 1 or rule 2.
- Aging never makes priority worse than base, and `eff` never wraps.
- Only one requester can hit per cycle. All other requesters age normally in that cycle.
- Reset mid-aging discards all age state. After reset release, requesters restart at base.
- The block has no combinational path from inputs to outputs.

Optional Feature:
- Macro: `PRIO_AGER_FLOOR_EN`.
- Defined: aging saturates at `AGE_FLOOR`, which reserves values below `AGE_FLOOR` for requests whose base is already below it. If `eff[k]` ≤ `AGE_FLOOR`, rule 3 leaves `eff[k]` unchanged; it never increases it toward the floor.
- Undefined: the floor is 0 and `AGE_FLOOR` is unused.

Test Plan:
All scenarios use N=8, PRIO_BITS=3, AGE_PERIOD=4.
- Reset: `rst_i`=1 for 2 cycles with `req_i`=8'hFF and base slot k = k → `req_o`=0, all `prio_o` slots = 3'd7. At the first edge after release: `req_o`=8'hFF and each slot = its base.
- Aging: only `req_i[2]`=1, base[2]=5, no grants → slot 2 = 5 after edges 1–3, 4 after edge 4, 3 after edge 8, 0 after edge 20, and stays 0 through edge 40.
- Grant restart: while slot 2 = 2, pulse `grant_i`=1 with `grant_sel_i`=2 → next edge slot 2 = 5. Next decrement comes 4 edges later. Slot 5, aging concurrently, keeps its own schedule.
- Drop and invalid grant:
  - Deassert `req_i[2]` at slot value 3 → next edge `req_o[2]`=0 and slot 2 = base.
  - With `req_o[4]`=0, `grant_i`=1 and `grant_sel_i`=4 → no change anywhere.
- Simultaneous events: `rst_i`=1 and `grant_i`=1 on the same edge → reset values only. Change `base_prio_i[2]` 5→1 mid-aging → `eff` is unaffected until the grant, after which slot 2 = 1.
- Floor (macro defined, `AGE_FLOOR`=1): base[3]=4 with a constant request → slot 3 reaches 1 at edge 12 and stays 1. base[6]=0 → slot 6 stays 0.
